// File: rtl/audio_serial_tx_if.sv
// Sample-pair stream into the serial audio transmitter: valid/ready handshake
// carrying a stereo pair of two's-complement samples.
interface audio_serial_tx_if #(
    parameter int WIDTH = 24
);
    logic                    in_valid;
    logic                    in_ready;
    logic signed [WIDTH-1:0] in_left;
    logic signed [WIDTH-1:0] in_right;

    modport master (output in_valid, output in_left, output in_right, input in_ready);
    modport slave  (input in_valid, input in_left, input in_right, output in_ready);
endinterface

// File: rtl/audio_serial_tx.sv
// Serial audio transmitter: one-entry sample buffer, internal SCLK divider,
// left-justified / I2S framing. Build option: AUDIO_TX_UNDERRUN_MUTE_EN.
module audio_serial_tx #(
    parameter int WIDTH      = 24,
    parameter int SLOT_WIDTH = 32,
    parameter int CLK_DIV    = 4
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             enable,
    input  logic             mode,
    audio_serial_tx_if.slave in_if,
    output logic             sclk,
    output logic             lrclk,
    output logic             sd,
    output logic             frame_start,
    output logic             underrun
);
    localparam int DIV_W = (2 * CLK_DIV > 2) ? $clog2(2 * CLK_DIV) : 1;
    localparam int BIT_W = $clog2(2 * SLOT_WIDTH);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(2 * CLK_DIV - 1);
    localparam logic [DIV_W-1:0] DIV_HIGH = DIV_W'(CLK_DIV);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(2 * SLOT_WIDTH - 1);
    localparam logic [BIT_W-1:0] SLOT_LEN = BIT_W'(SLOT_WIDTH);

    typedef enum logic {ST_IDLE, ST_RUN} state_t;

    state_t                  state_q;
    logic [DIV_W-1:0]        div_q, div_d;
    logic [BIT_W-1:0]        bit_q, bit_d;
    logic                    mode_q, mode_d;
    logic                    hold_full_q, hold_full_d;
    logic                    in_ready_q;
    logic signed [WIDTH-1:0] hold_left_q, hold_right_q;
    logic signed [WIDTH-1:0] frm_left_q, frm_right_q;
    logic signed [WIDTH-1:0] frm_left_d, frm_right_d;
    logic                    sclk_q, lrclk_q, sd_q;
    logic                    frame_start_q, underrun_q;
    logic                    accept, last_div, boundary, load;

    // Data bit for frame position b; I2S delays the MSB by one slot bit.
    function automatic logic sd_bit(input logic [WIDTH-1:0] l, input logic [WIDTH-1:0] r,
                                    input logic [BIT_W-1:0] b, input logic i2s);
        logic             right;
        logic [BIT_W-1:0] slot_bit;
        int               off;
        logic [WIDTH-1:0] sh;
        right    = (b >= SLOT_LEN);
        slot_bit = right ? (b - SLOT_LEN) : b;
        off      = int'(slot_bit) - (i2s ? 1 : 0);
        if (off < 0 || off >= WIDTH) return 1'b0;
        sh = (right ? r : l) << off;
        return sh[WIDTH-1];
    endfunction

    function automatic logic lr_level(input logic [BIT_W-1:0] b, input logic i2s);
        return (b < SLOT_LEN) ^ i2s;
    endfunction

    always_comb begin
        accept      = in_if.in_valid && in_ready_q;
        last_div    = (div_q == DIV_LAST);
        boundary    = enable && ((state_q == ST_IDLE) || (last_div && (bit_q == BIT_LAST)));
        load        = boundary && hold_full_q;
        hold_full_d = accept || (hold_full_q && !load);
        mode_d      = boundary ? mode : mode_q;
        frm_left_d  = frm_left_q;
        frm_right_d = frm_right_q;
        if (load) begin
            frm_left_d  = hold_left_q;
            frm_right_d = hold_right_q;
        end
`ifdef AUDIO_TX_UNDERRUN_MUTE_EN
        else if (boundary) begin
            frm_left_d  = '0;
            frm_right_d = '0;
        end
`endif
        if (boundary) begin
            div_d = '0;
            bit_d = '0;
        end else if (last_div) begin
            div_d = '0;
            bit_d = bit_q + 1'b1;
        end else begin
            div_d = div_q + 1'b1;
            bit_d = bit_q;
        end
    end

    // Buffer data only matters while hold_full_q is set, so it carries no reset.
    always_ff @(posedge clk) begin
        if (accept) begin
            hold_left_q  <= in_if.in_left;
            hold_right_q <= in_if.in_right;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q       <= ST_IDLE;
            div_q         <= '0;
            bit_q         <= '0;
            mode_q        <= 1'b0;
            hold_full_q   <= 1'b0;
            in_ready_q    <= 1'b0;
            frm_left_q    <= '0;
            frm_right_q   <= '0;
            sclk_q        <= 1'b0;
            lrclk_q       <= 1'b1;
            sd_q          <= 1'b0;
            frame_start_q <= 1'b0;
            underrun_q    <= 1'b0;
        end else begin
            hold_full_q   <= hold_full_d;
            in_ready_q    <= !hold_full_d;
            frame_start_q <= boundary;
            underrun_q    <= boundary && !hold_full_q;
            if (!enable) begin
                state_q <= ST_IDLE;
                div_q   <= '0;
                bit_q   <= '0;
                sclk_q  <= 1'b0;
                sd_q    <= 1'b0;
                lrclk_q <= !mode_q;
            end else begin
                state_q     <= ST_RUN;
                div_q       <= div_d;
                bit_q       <= bit_d;
                mode_q      <= mode_d;
                frm_left_q  <= frm_left_d;
                frm_right_q <= frm_right_d;
                sclk_q      <= (div_d >= DIV_HIGH);
                // sd/lrclk move only where sclk falls (start of each bit period).
                if (div_d == '0) begin
                    sd_q    <= sd_bit(frm_left_d, frm_right_d, bit_d, mode_d);
                    lrclk_q <= lr_level(bit_d, mode_d);
                end
            end
        end
    end

    assign in_if.in_ready = in_ready_q;
    assign sclk           = sclk_q;
    assign lrclk          = lrclk_q;
    assign sd             = sd_q;
    assign frame_start    = frame_start_q;
    assign underrun       = underrun_q;
endmodule

// File: tb/tb_audio_serial_tx.sv
// Scoreboard bench for audio_serial_tx (WIDTH=8, SLOT_WIDTH=16, CLK_DIV=2);
// decodes every complete frame at the pins and compares against queued pairs.
module tb_audio_serial_tx;
    logic       clk;
    logic       rstn;
    logic       enable;
    logic       mode;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_left;
    logic [7:0] in_right;
    logic       sclk, lrclk, sd, frame_start, underrun;

    audio_serial_tx_if #(.WIDTH(8)) in_if ();
    assign in_if.in_valid = in_valid;
    assign in_if.in_left  = in_left;
    assign in_if.in_right = in_right;
    assign in_ready       = in_if.in_ready;

    audio_serial_tx #(.WIDTH(8), .SLOT_WIDTH(16), .CLK_DIV(2)) dut (
        .clk         (clk),
        .rstn        (rstn),
        .enable      (enable),
        .mode        (mode),
        .in_if       (in_if),
        .sclk        (sclk),
        .lrclk       (lrclk),
        .sd          (sd),
        .frame_start (frame_start),
        .underrun    (underrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    typedef struct packed {
        logic [7:0] l;
        logic [7:0] r;
    } pair_t;

    pair_t       sb[$];
    pair_t       pend, cur, last;
    logic        pend_vld = 1'b0;
    logic        cur_mode = 1'b0;
    logic        in_frame = 1'b0;
    logic        sclk_prev = 1'b0;
    int          nbits, since_rise, bad_per;
    logic [31:0] got_sd, got_lr;

    task automatic check_frame();
        logic [31:0] exp_sd, exp_lr;
        logic [7:0]  sh;
        int          s, off;
        exp_sd = '0;
        exp_lr = '0;
        for (int b = 0; b < 32; b++) begin
            s   = b % 16;
            off = s - (cur_mode ? 1 : 0);
            exp_lr[31-b] = (b < 16) ^ cur_mode;
            if (off >= 0 && off < 8) begin
                sh = ((b < 16) ? cur.l : cur.r) << off;
                exp_sd[31-b] = sh[7];
            end
        end
        chk("sd_frame", got_sd, exp_sd);
        chk("lrclk_frame", got_lr, exp_lr);
        chk("sclk_period", bad_per, 0);
    endtask

    // Monitor/scoreboard: accepts are queued one cycle late so an accept on
    // the boundary edge itself is only visible to the following frame.
    always @(negedge clk) begin
        if (!rstn) begin
            sb.delete();
            pend_vld = 1'b0;
            last     = '0;
            in_frame = 1'b0;
        end else begin
            if (frame_start) begin
                chk("underrun", underrun, (sb.size() == 0));
                if (sb.size() != 0) begin
                    cur  = sb.pop_front();
                    last = cur;
                end else begin
`ifdef AUDIO_TX_UNDERRUN_MUTE_EN
                    cur = '0;
`else
                    cur = last;
`endif
                end
                cur_mode   = mode;
                nbits      = 0;
                since_rise = 0;
                bad_per    = 0;
                in_frame   = 1'b1;
            end
            if (pend_vld) sb.push_back(pend);
            pend_vld = 1'b0;
            if (in_valid && in_ready) begin
                pend.l   = in_left;
                pend.r   = in_right;
                pend_vld = 1'b1;
            end
            if (in_frame) begin
                since_rise++;
                if (!sclk_prev && sclk) begin
                    if (nbits > 0 && since_rise != 4) bad_per++;
                    since_rise         = 0;
                    got_sd[31-nbits]   = sd;
                    got_lr[31-nbits]   = lrclk;
                    nbits++;
                    if (nbits == 32) begin
                        check_frame();
                        in_frame = 1'b0;
                    end
                end
            end
        end
        sclk_prev = sclk;
    end

    task automatic send(input logic [7:0] l, input logic [7:0] r, input bit keep);
        int n;
        n = 0;
        @(posedge clk); #1;
        in_valid = 1'b1;
        in_left  = l;
        in_right = r;
        while (1) begin
            @(negedge clk);
            if (in_ready) break;
            n++;
            if (n > 1000) begin
                chk("send_timeout", 0, 1);
                break;
            end
        end
        @(posedge clk); #1;
        if (!keep) in_valid = 1'b0;
        @(negedge clk);
        chk("ready_drop", in_ready, 0);
    endtask

    task automatic wait_frames(input int n);
        int seen, cyc;
        seen = 0;
        cyc  = 0;
        while (seen < n) begin
            @(negedge clk);
            if (frame_start) seen++;
            cyc++;
            if (cyc > 300 * n) begin
                chk("frame_timeout", seen, n);
                break;
            end
        end
    endtask

    initial begin
        rstn = 1'b0; enable = 1'b0; mode = 1'b0;
        in_valid = 1'b0; in_left = '0; in_right = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_sclk", sclk, 0);
        chk("rst_lrclk", lrclk, 1);
        chk("rst_sd", sd, 0);
        chk("rst_ready", in_ready, 0);
        chk("rst_fs", frame_start, 0);
        chk("rst_ur", underrun, 0);
        @(posedge clk); #1 rstn = 1'b1;
        @(posedge clk); @(negedge clk);
        chk("rel_ready", in_ready, 1);

        // Left-justified basic frame, then an underrun repeat
        send(8'hA5, 8'h3C, 0);
        @(posedge clk); #1 enable = 1'b1;
        wait_frames(2);

        // I2S with the same data
        @(posedge clk); #1 mode = 1'b1;
        send(8'hA5, 8'h3C, 0);
        wait_frames(2);

        // Back-pressure: valid held high across three pairs
        @(posedge clk); #1 mode = 1'b0;
        send(8'h11, 8'hE2, 1);
        send(8'h33, 8'hC4, 1);
        send(8'h55, 8'h96, 0);
        wait_frames(4);

        // Underrun after a single pair
        send(8'h81, 8'h7E, 0);
        wait_frames(3);

        // Mode switch at bit 10 of an LJ frame
        wait_frames(1);
        repeat (40) @(posedge clk);
        #1 mode = 1'b1;
        wait_frames(2);

        // Mid-frame disable at bit 5 of an I2S frame
        wait_frames(1);
        repeat (20) @(posedge clk);
        #1 enable = 1'b0;
        @(negedge clk);
        chk("dis_sclk", sclk, 0);
        chk("dis_sd", sd, 0);
        chk("dis_lrclk", lrclk, !cur_mode);
        send(8'h5A, 8'hC3, 0);
        @(posedge clk); #1 enable = 1'b1;
        @(posedge clk); @(negedge clk);
        chk("reen_fs", frame_start, 1);

        // Mid-frame reset
        repeat (24) @(posedge clk);
        #1 rstn = 1'b0;
        @(posedge clk); @(negedge clk);
        chk("rst2_sclk", sclk, 0);
        chk("rst2_lrclk", lrclk, 1);
        chk("rst2_sd", sd, 0);
        chk("rst2_ready", in_ready, 0);
        @(posedge clk); #1;
        enable = 1'b0;
        rstn   = 1'b1;
        @(posedge clk); @(negedge clk);
        chk("rst2_rel_ready", in_ready, 1);
        chk("rst2_rel_lrclk", lrclk, 1);
        @(posedge clk); #1 enable = 1'b1;
        @(posedge clk); @(negedge clk);
        chk("rst2_fs", frame_start, 1);
        wait_frames(2);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
